// File: rtl/vdispatcher_fill.sv
// Serial-to-parallel fill stage feeding the vector dispatcher shift chain.
// Optional macro VDISPATCHER_FILL_BYPASS_EN lets a word be accepted while a held group transfers.
module vdispatcher_fill #(
  parameter int unsigned NUMENTRIES = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CNTW       = 3
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  input  logic                          flush_req,
  output logic                          out_valid,
  output logic [NUMENTRIES*WIDTH-1:0]   out_data,
  output logic [NUMENTRIES-1:0]         out_mask,
  input  logic                          out_ready,
  output logic [CNTW-1:0]               count
);

  localparam int unsigned DW = NUMENTRIES * WIDTH;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(NUMENTRIES);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic [NUMENTRIES-1:0] mask_q,  mask_d;
  logic [DW-1:0]         data_q,  data_d;
  logic                  accept;

`ifdef VDISPATCHER_FILL_BYPASS_EN
  // While a group is held, a new word may enter only in the cycle the shifter loads it.
  assign in_ready = (state_q == S_FILL) || out_ready;
`else
  assign in_ready = (state_q == S_FILL);
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = data_q;
  assign out_mask  = mask_q;
  assign count     = count_q;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= S_FILL;
      count_q <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mask_d  = mask_q;
    data_d  = data_q;

    if (state_q == S_FILL) begin
      if (accept) begin
        for (int unsigned k = 0; k < NUMENTRIES; k++) begin
          if (count_q == CNTW'(k)) begin
            data_d[k*WIDTH +: WIDTH] = in_data;
            mask_d[k]                = 1'b1;
          end
        end
        count_d = count_q + CNTW'(1);
      end
      // A same-cycle word is counted before deciding whether a flush closes the group.
      if ((count_d == FULL_CNT) || (flush_req && (count_d != '0))) begin
        state_d = S_HOLD;
      end
    end else begin
      if (out_ready) begin
        state_d = S_FILL;
        count_d = '0;
        mask_d  = '0;
        data_d  = '0;
`ifdef VDISPATCHER_FILL_BYPASS_EN
        if (accept) begin
          data_d[WIDTH-1:0] = in_data;
          mask_d[0]         = 1'b1;
          count_d           = CNTW'(1);
          if (flush_req) begin
            state_d = S_HOLD;
          end
        end
`endif
      end
    end
  end

endmodule

// File: doc/vdispatcher_fill.md
# vdispatcher_fill

Serial-to-parallel fill stage directly upstream of the vector dispatcher shift chain. It accepts one WIDTH-bit dispatch word per cycle through a valid/ready handshake and packs the words into an NUMENTRIES-slot group. It presents each full or flushed-partial group, with a per-slot valid mask, as the parallel load image for the shifter. The downstream shifter loads the image when it asserts `out_ready`.

## Interface
- `NUMENTRIES`, default 4: slots per group; must be ≥2.
- `WIDTH`, default 32: bits per slot.
- `CNTW`, default 3: width of `count`; must satisfy 2^CNTW > NUMENTRIES.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-high (asserted when 1).
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  WIDTH  upstream dispatch word.
- `in_ready`  out  1  stage can accept `in_data` this cycle.
- `flush_req`  in  1  close the current partial group; single-cycle pulse.
- `out_valid`  out  1  group image available.
- `out_data`  out  NUMENTRIES*WIDTH  group image; slot k occupies bits [(k+1)*WIDTH-1 : k*WIDTH].
- `out_mask`  out  NUMENTRIES  bit k set when slot k holds a word.
- `out_ready`  in  1  shifter loads the image this cycle.
- `count`  out  CNTW  number of words currently filled (0..NUMENTRIES).

## Operation
- Two states:
  - FILL: collecting words; `in_ready`=1, `out_valid`=0.
  - HOLD: presenting a group; `in_ready`=0 unless bypass is compiled in; `out_valid`=1.
- Accept means `in_valid && in_ready`. An accepted word is written to slot `count`, its mask bit is set, and `count` increments.
- The first word of a group always lands in slot 0. Slots are filled strictly in ascending order.
- FILL→HOLD transitions:
  - The accept that makes `count`=NUMENTRIES.
  - `flush_req` with the post-accept count ≥1. When an accept and a flush occur in the same cycle, the word is included before the group closes.
- `flush_req` with `count`=0 and no accept is ignored, so no empty group is ever emitted.
- `flush_req` in HOLD is ignored.
- HOLD→FILL on `out_valid && out_ready`. In the same edge `count`, `out_mask` and all slots clear to 0.
- Unfilled slots in a partial group read as 0.
- While `out_valid && !out_ready`, `out_data`, `out_mask` and `count` are held stable.
- `in_data` is not inspected; no arithmetic is performed on the data path.

## Timing
- Reset values while `resetn`=1: state FILL, `count`=0, `out_valid`=0, `out_data`=0, `out_mask`=0, `in_ready`=1. Inputs are ignored while reset is asserted.
- Reset asserted mid-group discards every collected word immediately (asynchronously). No partial group is emitted afterward.
- Latency: the word that completes a group, or the flush, at edge N gives `out_valid`=1 in the cycle after edge N.
- Minimum group period is NUMENTRIES+1 cycles without bypass, and NUMENTRIES cycles with bypass.
- `in_ready`, `out_valid`, `out_data`, `out_mask` and `count` are registered or decoded from registered state. The one exception is the bypass path described below.
- `out_ready` asserted while `out_valid`=0 has no effect.

## Configuration
- `VDISPATCHER_FILL_BYPASS_EN`
  - Defined: in HOLD, `in_ready` = `out_ready`. A word accepted in the same cycle as the group transfer becomes slot 0 of the next group, giving `count`=1 and `out_mask`=...0001 after the edge.
    - If NUMENTRIES words would be needed in that single cycle, the normal fill rules still apply.
    - A `flush_req` coinciding with this bypass accept closes a 1-word group: HOLD is re-entered directly.
    - This adds a combinational path from `out_ready` to `in_ready`.
  - Undefined: `in_ready`=0 throughout HOLD. There is no combinational input→output path.

## Test plan
- Reset, then accept 0xA0..0xA3 on 4 consecutive cycles with `out_ready`=0 → `out_valid`=1 one cycle after 0xA3. `out_data` = {0xA3,0xA2,0xA1,0xA0}, `out_mask`=4'b1111, `in_ready`=0. All values hold for 5 stalled cycles, then the transfer clears `count` to 0.
- Accept 0xB0, 0xB1, then `flush_req` alone → `out_mask`=4'b0011, slots 2–3 = 0, `count`=2. `flush_req` at `count`=0 → `out_valid` stays 0.
- Accept 0xC0 together with `flush_req` in the same cycle at `count`=2 → group mask 4'b0111 with 0xC0 in slot 2.
- Assert `resetn` asynchronously (mid-cycle) with `count`=3 → `count`, `out_mask` and `out_data` read 0 before the next edge. After release, a single accept and flush yields mask 4'b0001.
- Continuous `in_valid` and `out_ready`=1 for 20 cycles:
  - Without the macro: 4 groups, each followed by one bubble cycle where `in_ready`=0.
  - With `VDISPATCHER_FILL_BYPASS_EN`: 5 groups and no bubble.
  - In both builds the word order is preserved.
